// File: rtl/map_left_and_right.sv
// ---------------------------------------------------------------------------
// map_left_and_right
//
// Purpose
//   Second stage of the star mapper. The upstream stage has already found a
//   star's seed column and its top and bottom rows. On a one-cycle start pulse
//   this block latches those values. It then walks the star's middle row
//   through a synchronous image ROM, first leftwards and then rightwards from
//   the seed, to find the left-most and right-most lit columns. Finally it
//   reports both extents and the star centre with a one-cycle done pulse.
//
// Ports
//   clk          clock
//   resetn       synchronous, active-low reset
//   start        one-cycle request; x_seed/most_top/most_bottom valid with it
//   x_seed       seed column of the star
//   most_top     top row of the star
//   most_bottom  bottom row of the star
//   mem_addr     ROM address, mid_y*X_RES + probe_x (combinational from regs)
//   mem_q        ROM data, valid the cycle after the address is presented
//   busy         high from the cycle after start through the done cycle
//   most_left    left-most lit column on the middle row
//   most_right   right-most lit column on the middle row
//   centre_x     (most_left + most_right) >> 1
//   centre_y     (most_top + most_bottom) >> 1
//   done         one-cycle pulse; all results valid from this cycle on
// ---------------------------------------------------------------------------
module map_left_and_right #(
    parameter int X_SZ      = 6,
    parameter int Y_SZ      = 6,
    parameter int ADDR_SZ   = 12,
    parameter int COL_SZ    = 3,
    parameter int X_RES     = 60,
    parameter int THRESHOLD = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [X_SZ-1:0]    x_seed,
    input  logic [Y_SZ-1:0]    most_top,
    input  logic [Y_SZ-1:0]    most_bottom,
    output logic [ADDR_SZ-1:0] mem_addr,
    input  logic [COL_SZ-1:0]  mem_q,
    output logic               busy,
    output logic [X_SZ-1:0]    most_left,
    output logic [X_SZ-1:0]    most_right,
    output logic [X_SZ-1:0]    centre_x,
    output logic [Y_SZ-1:0]    centre_y,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        L_WAIT = 3'd1,
        L_CHK  = 3'd2,
        R_INIT = 3'd3,
        R_WAIT = 3'd4,
        R_CHK  = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [X_SZ-1:0]   X_LAST  = X_SZ'(X_RES - 1);
    localparam logic [COL_SZ-1:0] LIT_MIN = COL_SZ'(THRESHOLD);

    // State and datapath registers
    state_t            state_reg,      state_next;
    logic [X_SZ-1:0]   probe_x_reg,    probe_x_next;
    logic [X_SZ-1:0]   seed_reg,       seed_next;
    logic [Y_SZ-1:0]   mid_y_reg,      mid_y_next;
    logic [X_SZ-1:0]   left_reg,       left_next;
    logic [X_SZ-1:0]   right_reg,      right_next;
    logic [X_SZ-1:0]   centre_x_reg,   centre_x_next;
    logic [Y_SZ-1:0]   centre_y_reg,   centre_y_next;

    // Sums carry one extra bit so the halving never loses the MSB.
    logic [Y_SZ:0]     y_sum;
    logic [X_SZ:0]     x_sum;
    logic              lit;

    assign y_sum = {1'b0, most_top} + {1'b0, most_bottom};
    assign x_sum = {1'b0, left_next} + {1'b0, right_next};
    assign lit   = (mem_q > LIT_MIN);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            probe_x_reg  <= '0;
            seed_reg     <= '0;
            mid_y_reg    <= '0;
            left_reg     <= '0;
            right_reg    <= '0;
            centre_x_reg <= '0;
            centre_y_reg <= '0;
        end else begin
            state_reg    <= state_next;
            probe_x_reg  <= probe_x_next;
            seed_reg     <= seed_next;
            mid_y_reg    <= mid_y_next;
            left_reg     <= left_next;
            right_reg    <= right_next;
            centre_x_reg <= centre_x_next;
            centre_y_reg <= centre_y_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        probe_x_next  = probe_x_reg;
        seed_next     = seed_reg;
        mid_y_next    = mid_y_reg;
        left_next     = left_reg;
        right_next    = right_reg;
        centre_x_next = centre_x_reg;
        centre_y_next = centre_y_reg;

        unique case (state_reg)
            IDLE: begin
                // start is only honoured here, so a pulse that arrives while
                // a scan is running (the DONE cycle included) is dropped.
                if (start) begin
                    mid_y_next   = y_sum[Y_SZ:1];
                    seed_next    = x_seed;
                    probe_x_next = x_seed;
                    left_next    = x_seed;
                    right_next   = x_seed;
                    state_next   = L_WAIT;
                end
            end

            // The address is held here for one cycle so the sync ROM can
            // return the pixel in the following check state.
            L_WAIT: state_next = L_CHK;

            L_CHK: begin
                if (lit) begin
                    left_next = probe_x_reg;
                    if (probe_x_reg == '0) begin
                        // Column 0 is lit; stop here instead of wrapping.
                        state_next = R_INIT;
                    end else begin
                        probe_x_next = probe_x_reg - 1'b1;
                        state_next   = L_WAIT;
                    end
                end else if (probe_x_reg == seed_reg) begin
                    // Dark seed: nothing to scan; extents stay at the seed.
                    state_next = DONE;
                end else begin
                    state_next = R_INIT;
                end
            end

            R_INIT: begin
                // The seed itself is already known to be lit, so the right
                // walk starts one column past it.
                if (seed_reg == X_LAST) begin
                    state_next = DONE;
                end else begin
                    probe_x_next = seed_reg + 1'b1;
                    state_next   = R_WAIT;
                end
            end

            R_WAIT: state_next = R_CHK;

            R_CHK: begin
                if (lit) begin
                    right_next = probe_x_reg;
                    if (probe_x_reg == X_LAST) begin
                        state_next = DONE;
                    end else begin
                        probe_x_next = probe_x_reg + 1'b1;
                        state_next   = R_WAIT;
                    end
                end else begin
                    state_next = DONE;
                end
            end

            DONE: state_next = IDLE;

            default: state_next = IDLE;
        endcase

        // Capture the centre on the edge that enters DONE, using the extents
        // as they will be after that edge, so the centre is valid together
        // with the done pulse.
        if ((state_next == DONE) && (state_reg != DONE)) begin
            centre_x_next = x_sum[X_SZ:1];
            centre_y_next = mid_y_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign mem_addr   = ADDR_SZ'(mid_y_reg) * ADDR_SZ'(X_RES) + ADDR_SZ'(probe_x_reg);
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign most_left  = left_reg;
    assign most_right = right_reg;
    assign centre_x   = centre_x_reg;
    assign centre_y   = centre_y_reg;

endmodule
